// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - commit-trace capture buffer for (PC, write-back data) pairs
module pipeline_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PTR_W  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Arm,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] TrigPC,
  input  logic [PTR_W:0]    PostCount,
  input  logic              InValid,
  input  logic [ADDR_W-1:0] InPC,
  input  logic [DATA_W-1:0] InData,
  input  logic              RdEn,
  output logic [ADDR_W-1:0] RdPC,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic [PTR_W:0]    Count,
  output logic [1:0]        State,
  output logic              Triggered,
  output logic              Wrapped
);
  localparam int DEPTH = 2 ** PTR_W;
  localparam logic [PTR_W:0] FULL      = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] FULL_LESS = (PTR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d, post_q, post_d, post_count_q, post_count_d;
  logic              mode_q, mode_d, triggered_q, triggered_d, wrapped_q, wrapped_d;
  logic [ADDR_W-1:0] trig_pc_q, trig_pc_d, rd_pc_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_en, rd_en;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    post_d       = post_q;
    post_count_d = post_count_q;
    mode_d       = mode_q;
    trig_pc_d    = trig_pc_q;
    triggered_d  = triggered_q;
    wrapped_d    = wrapped_q;
    rd_valid_d   = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    if (Arm) begin
      // Arm beats a simultaneous RdEn and restarts from any state.
      state_d      = S_CAPTURE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      post_d       = '0;
      triggered_d  = 1'b0;
      wrapped_d    = 1'b0;
      mode_d       = Mode;
      trig_pc_d    = TrigPC;
      post_count_d = PostCount;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (RdEn && count_q != '0) begin
            rd_en      = 1'b1;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
            rd_valid_d = 1'b1;
          end
        end
        S_CAPTURE, S_POST: begin
          if (InValid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (state_q == S_CAPTURE && !mode_q) begin
              count_d = count_q + 1'b1;
              if (count_q == FULL_LESS) state_d = S_DONE;
            end else begin
              // Circular mode: a full buffer drops its oldest entry.
              if (count_q == FULL) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                wrapped_d = 1'b1;
              end else begin
                count_d = count_q + 1'b1;
              end
              if (state_q == S_CAPTURE) begin
                if (InPC == trig_pc_q) begin
                  triggered_d = 1'b1;
                  if (post_count_q == '0) begin
                    state_d = S_DONE;
                  end else begin
                    state_d = S_POST;
                    post_d  = post_count_q;
                  end
                end
              end else begin
                post_d = post_q - 1'b1;
                if (post_q == (PTR_W + 1)'(1)) state_d = S_DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      post_q       <= '0;
      post_count_q <= '0;
      mode_q       <= 1'b0;
      trig_pc_q    <= '0;
      triggered_q  <= 1'b0;
      wrapped_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_pc_q      <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      post_q       <= post_d;
      post_count_q <= post_count_d;
      mode_q       <= mode_d;
      trig_pc_q    <= trig_pc_d;
      triggered_q  <= triggered_d;
      wrapped_q    <= wrapped_d;
      rd_valid_q   <= rd_valid_d;
      if (rd_en) begin
        rd_pc_q   <= mem_pc[rd_ptr_q];
        rd_data_q <= mem_data[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en && !Rst) begin
      mem_pc[wr_ptr_q]   <= InPC;
      mem_data[wr_ptr_q] <= InData;
    end
  end

  assign RdPC      = rd_pc_q;
  assign RdData    = rd_data_q;
  assign RdValid   = rd_valid_q;
  assign Count     = count_q;
  assign State     = state_q;
  assign Triggered = triggered_q;
  assign Wrapped   = wrapped_q;
endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb/tb_pipeline_trace_buffer.sv - scoreboard bench for pipeline_trace_buffer
module tb_pipeline_trace_buffer;
  logic        Clk = 1'b0;
  logic        Rst, Arm, Mode, InValid, RdEn;
  logic [31:0] TrigPC, InPC, InData;
  logic [4:0]  PostCount;
  logic [31:0] RdPC, RdData;
  logic        RdValid, Triggered, Wrapped;
  logic [4:0]  Count;
  logic [1:0]  State;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  pipeline_trace_buffer dut (
    .Clk(Clk), .Rst(Rst), .Arm(Arm), .Mode(Mode), .TrigPC(TrigPC),
    .PostCount(PostCount), .InValid(InValid), .InPC(InPC), .InData(InData),
    .RdEn(RdEn), .RdPC(RdPC), .RdData(RdData), .RdValid(RdValid),
    .Count(Count), .State(State), .Triggered(Triggered), .Wrapped(Wrapped)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Rst && RdValid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pop: got pc=%h data=%h, required no RdValid", RdPC, RdData);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({RdPC, RdData} !== e) begin
          n_bad++;
          $display("FAIL pop: got pc=%h data=%h, required pc=%h data=%h",
                   RdPC, RdData, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic arm(input logic m, input logic [31:0] tpc, input logic [4:0] pc_n);
    Arm = 1'b1; Mode = m; TrigPC = tpc; PostCount = pc_n;
    cyc();
    // Scramble latched inputs to show they are ignored after Arm.
    Arm = 1'b0; Mode = ~m; TrigPC = 32'h0; PostCount = 5'd1;
  endtask

  task automatic sample(input logic [31:0] pc);
    InValid = 1'b1; InPC = pc; InData = pc + 32'h100;
    cyc();
    InValid = 1'b0;
  endtask

  task automatic expect_range(input logic [31:0] first, input logic [31:0] last);
    for (logic [31:0] p = first; p <= last; p += 4) sb.push_back({p, p + 32'h100});
  endtask

  task automatic readout(input int n);
    for (int i = 0; i < n; i++) begin
      RdEn = 1'b1;
      cyc();
      chk("rd_valid_after_rden", {31'd0, RdValid}, 32'd1);
    end
    RdEn = 1'b0;
    cyc();
    chk("scoreboard_drained", sb.size(), 32'd0);
  endtask

  task automatic chk_status(input string tag, input logic [1:0] st, input logic [4:0] cnt,
                            input logic trg, input logic wrp);
    chk({tag, "_state"}, {30'd0, State}, {30'd0, st});
    chk({tag, "_count"}, {27'd0, Count}, {27'd0, cnt});
    chk({tag, "_triggered"}, {31'd0, Triggered}, {31'd0, trg});
    chk({tag, "_wrapped"}, {31'd0, Wrapped}, {31'd0, wrp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; Arm = 1'b0; Mode = 1'b0; TrigPC = '0; PostCount = '0;
    InValid = 1'b0; InPC = '0; InData = '0; RdEn = 1'b0;
    cyc(); cyc();
    Rst = 1'b0;
    chk_status("reset", 2'd0, 5'd0, 1'b0, 1'b0);
    chk("reset_rdvalid", {31'd0, RdValid}, 32'd0);
    RdEn = 1'b1; cyc(); RdEn = 1'b0;
    chk("empty_pop_rdvalid", {31'd0, RdValid}, 32'd0);

    // Fill-and-stop: 20 offered, first 16 kept.
    arm(1'b0, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      sample(i * 4);
      if (i == 14) chk("fill_state_before_full", {30'd0, State}, 32'd1);
      if (i == 15) chk_status("fill_full", 2'd3, 5'd16, 1'b0, 1'b0);
    end
    chk_status("fill_end", 2'd3, 5'd16, 1'b0, 1'b0);
    expect_range(32'h00, 32'h3C);
    readout(16);
    RdEn = 1'b1; cyc(); RdEn = 1'b0;
    chk("fill_17th_pop", {31'd0, RdValid}, 32'd0);
    chk("fill_hold_rdpc", RdPC, 32'h3C);

    // Circular with trigger at 0x40, 3 post samples.
    arm(1'b1, 32'h40, 5'd3);
    for (int i = 0; i < 20; i++) begin
      sample(i * 4);
      if (i == 15) chk_status("circ_full", 2'd1, 5'd16, 1'b0, 1'b0);
      if (i == 16) chk_status("circ_trig", 2'd2, 5'd16, 1'b1, 1'b1);
      if (i == 18) chk("circ_post_state", {30'd0, State}, 32'd2);
    end
    chk_status("circ_done", 2'd3, 5'd16, 1'b1, 1'b1);
    expect_range(32'h10, 32'h4C);
    readout(16);

    // Same, with idle gaps during POST.
    arm(1'b1, 32'h40, 5'd3);
    for (int i = 0; i <= 16; i++) sample(i * 4);
    for (int i = 17; i < 20; i++) begin
      chk("gap_state_post", {30'd0, State}, 32'd2);
      cyc();
      chk("gap_state_idlecycle", {30'd0, State}, 32'd2);
      sample(i * 4);
    end
    chk_status("gap_done", 2'd3, 5'd16, 1'b1, 1'b1);
    expect_range(32'h10, 32'h4C);
    readout(16);

    // Trigger with zero post samples.
    arm(1'b1, 32'h08, 5'd0);
    sample(32'h00); sample(32'h04); sample(32'h08);
    chk_status("post0_done", 2'd3, 5'd3, 1'b1, 1'b0);
    sample(32'h0C);
    chk("post0_count_after_extra", {27'd0, Count}, 32'd3);
    expect_range(32'h00, 32'h08);
    readout(3);
    RdEn = 1'b1; cyc(); RdEn = 1'b0;
    chk("post0_extra_pop", {31'd0, RdValid}, 32'd0);

    // Re-arm during POST, then reset mid-capture.
    arm(1'b1, 32'h08, 5'd5);
    sample(32'h00); sample(32'h04); sample(32'h08);
    chk("rearm_in_post", {30'd0, State}, 32'd2);
    arm(1'b1, 32'h1000, 5'd2);
    chk_status("rearm", 2'd1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sample(i * 4);
    chk("pre_reset_count", {27'd0, Count}, 32'd5);
    Rst = 1'b1; cyc(); Rst = 1'b0;
    chk_status("midreset", 2'd0, 5'd0, 1'b0, 1'b0);
    chk("midreset_rdpc", RdPC, 32'd0);
    chk("midreset_rddata", RdData, 32'd0);
    chk("midreset_rdvalid", {31'd0, RdValid}, 32'd0);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
- Synthesizable commit-trace capture buffer. It records (PC, write-back data) pairs from the write-back stage of the pipelined MIPS core into a circular RAM of depth DEPTH.
- Replaces per-cycle console inspection of PCValue/WriteData with on-chip capture.
- Two capture modes: fill-and-stop, and circular with PC-match trigger plus post-trigger sample count.
- Captured samples are read back oldest-first through a pop interface once capture has ended.

Parameters:
- DATA_W, 32, width of captured write-back data.
- ADDR_W, 32, width of captured PC.
- PTR_W, 4, pointer width. DEPTH = 2**PTR_W (16 entries).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Arm  in  1  single-cycle pulse; starts a new capture and latches Mode, TrigPC, PostCount.
- Mode  in  1  0 = fill-and-stop, 1 = circular with trigger.
- TrigPC  in  ADDR_W  trigger PC value (Mode 1 only).
- PostCount  in  PTR_W+1  number of samples captured after the trigger sample, 0..DEPTH.
- InValid  in  1  sample qualifier (write-back commit).
- InPC  in  ADDR_W  PC of the committing instruction.
- InData  in  DATA_W  write-back data.
- RdEn  in  1  pop the oldest entry.
- RdPC  out  ADDR_W  popped PC.
- RdData  out  DATA_W  popped data.
- RdValid  out  1  RdPC/RdData updated this cycle.
- Count  out  PTR_W+1  number of entries held, 0..DEPTH.
- State  out  2  IDLE=0, CAPTURE=1, POST=2, DONE=3.
- Triggered  out  1  sticky; trigger seen in current capture.
- Wrapped  out  1  sticky; at least one oldest entry was overwritten.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - State=IDLE; wr_ptr=rd_ptr=0; Count=0; post counter=0.
  - RdValid=0, RdPC=0, RdData=0, Triggered=0, Wrapped=0.
  - RAM contents are not cleared.
  - Reset mid-capture gives the identical result.
- Arm (accepted in any state):
  - Next state CAPTURE.
  - Pointers, Count, Triggered, Wrapped cleared.
  - Mode, TrigPC, PostCount latched; later changes to these inputs are ignored until the next Arm.
  - Arm and RdEn in the same cycle: Arm wins, no pop, RdValid=0.
  - Arm in CAPTURE or POST restarts the capture.
- IDLE:
  - InValid ignored.
  - Readout permitted (contents of the previous capture).
- CAPTURE, Mode 0:
  - Each InValid cycle writes mem[wr_ptr], wr_ptr++, Count++.
  - The write that makes Count=DEPTH moves State to DONE on the same edge.
  - TrigPC is ignored.
- CAPTURE, Mode 1:
  - Each InValid cycle writes mem[wr_ptr], wr_ptr++.
  - If Count<DEPTH: Count++.
  - If Count==DEPTH: rd_ptr++, Count unchanged, Wrapped=1.
  - InValid with InPC==TrigPC: the sample is written and Triggered=1.
    - PostCount==0: next state DONE.
    - Otherwise: next state POST, post counter=PostCount.
- POST:
  - Each InValid cycle writes using the same circular rule and decrements the post counter.
  - The counter reaching 0 moves State to DONE on that edge.
  - Further TrigPC matches are ignored.
- DONE:
  - InValid ignored; holds until Arm or Rst.
- Readout (IDLE or DONE only):
  - RdEn with Count>0: RdPC/RdData <= mem[rd_ptr], rd_ptr++, Count--, RdValid=1 on the next cycle (1-cycle latency).
  - Otherwise RdValid=0; RdPC/RdData hold their last value.
  - RdEn is ignored in CAPTURE and POST.
- Pointers wrap modulo DEPTH.
- Count==DEPTH means full and is distinguished from empty by the extra bit.
- InValid cycles with InValid=0 never write and never decrement the post counter.

Test Plan:
1. Rst held 2 cycles then released -> State=0, Count=0, RdValid=0, Triggered=0, Wrapped=0. RdEn -> RdValid stays 0.
2. Mode 0: Arm, then 20 consecutive InValid samples, PC=0x00,0x04,..., data=PC+0x100.
   - State=3 after the 16th sample; Count=16.
   - 16 RdEn pulses -> RdPC 0x00..0x3C in order, RdData=RdPC+0x100, RdValid one cycle after each RdEn.
   - 17th RdEn -> RdValid=0.
3. Mode 1: TrigPC=0x40, PostCount=3, feed PC 0x00..0x4C step 4 (20 samples).
   - State=2 after PC 0x40; DONE after 0x4C.
   - Count=16, Triggered=1, Wrapped=1.
   - Readout yields 0x10..0x4C.
4. Repeat scenario 3 with InValid low on alternate cycles during POST -> same final contents; DONE only after the third valid post sample.
5. Mode 1: TrigPC=0x08, PostCount=0, feed 0x00,0x04,0x08,0x0C.
   - DONE after 0x08; Count=3, Wrapped=0.
   - 0x0C not captured.
6. Arm during POST -> State=1, Count=0, Triggered=0. Rst asserted during CAPTURE with Count=5 -> all reset values on the next cycle.
